// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates ROB/BRU/decode PC redirects into the fetcher,
// issues flush pulses and an epoch tag, and filters stale redirects during drain.
module fetch_redirect_ctrl #(
    parameter type T            = logic [31:0],
    parameter int  ROB_TAG_W    = 5,
    parameter int  EPOCH_W      = 3,
    parameter int  DRAIN_CYCLES = 2,
    parameter T    RESET_PC     = T'(0)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rob_flush_valid,
    input  T                     rob_flush_pc,
    input  logic                 bru_redirect_valid,
    input  T                     bru_redirect_pc,
    input  logic [ROB_TAG_W-1:0] bru_redirect_tag,
    input  logic [ROB_TAG_W-1:0] rob_head_tag,
    input  logic                 dec_redirect_valid,
    input  T                     dec_redirect_pc,
    output logic                 take_branch,
    output T                     branch_loc,
    output logic                 flush_frontend,
    output logic                 flush_backend,
    output logic [EPOCH_W-1:0]   epoch,
    output logic                 busy
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [ROB_TAG_W-1:0] rec_tag, age_new, age_rec;
    logic                 rec_valid;
    logic                 acc_rob, acc_bru, acc_dec, accept;
    T                     win_pc;

    // Ages are relative to the ROB head so tag wrap-around orders correctly.
    always_comb begin
        age_new = bru_redirect_tag - rob_head_tag;
        age_rec = rec_tag - rob_head_tag;
        acc_rob = rob_flush_valid;
        acc_bru = !rob_flush_valid && bru_redirect_valid &&
                  (state == IDLE || (rec_valid && age_new < age_rec));
        acc_dec = state == IDLE && !rob_flush_valid && !bru_redirect_valid && dec_redirect_valid;
        accept  = acc_rob || acc_bru || acc_dec;
        win_pc  = acc_rob ? rob_flush_pc : acc_bru ? bru_redirect_pc : dec_redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (accept) begin
            state_next = DRAIN;
            cnt_next   = CW'(DRAIN_CYCLES);
        end else if (state == DRAIN) begin
            cnt_next   = cnt - 1'b1;
            state_next = cnt == CW'(1) ? IDLE : DRAIN;
        end
    end

    always_comb busy = state == DRAIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            take_branch    <= 1'b0;
            branch_loc     <= RESET_PC;
            flush_frontend <= 1'b0;
            flush_backend  <= 1'b0;
            epoch          <= '0;
            rec_tag        <= '0;
            rec_valid      <= 1'b0;
        end else begin
            take_branch    <= accept;
            flush_frontend <= accept;
            flush_backend  <= acc_rob;
            if (accept) begin
                branch_loc <= win_pc;
                epoch      <= epoch + 1'b1;
            end
            if (acc_rob) rec_valid <= 1'b0;
            if (acc_bru) begin
                rec_tag   <= bru_redirect_tag;
                rec_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed self-checking bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;
    logic        clk = 0;
    logic        reset;
    logic        rob_flush_valid, bru_redirect_valid, dec_redirect_valid;
    logic [31:0] rob_flush_pc, bru_redirect_pc, dec_redirect_pc;
    logic [4:0]  bru_redirect_tag, rob_head_tag;
    logic        take_branch, flush_frontend, flush_backend, busy;
    logic [31:0] branch_loc;
    logic [2:0]  epoch;
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_redirect_ctrl dut (
        .clk(clk), .reset(reset),
        .rob_flush_valid(rob_flush_valid), .rob_flush_pc(rob_flush_pc),
        .bru_redirect_valid(bru_redirect_valid), .bru_redirect_pc(bru_redirect_pc),
        .bru_redirect_tag(bru_redirect_tag), .rob_head_tag(rob_head_tag),
        .dec_redirect_valid(dec_redirect_valid), .dec_redirect_pc(dec_redirect_pc),
        .take_branch(take_branch), .branch_loc(branch_loc),
        .flush_frontend(flush_frontend), .flush_backend(flush_backend),
        .epoch(epoch), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rob_flush_valid    = 0;
        bru_redirect_valid = 0;
        dec_redirect_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic outs(input string tag, input logic tb, input logic [31:0] loc,
                        input logic ff, input logic fb, input logic [2:0] ep, input logic bz);
        check({tag, ".take"}, 32'(take_branch), 32'(tb));
        check({tag, ".loc"}, branch_loc, loc);
        check({tag, ".ffe"}, 32'(flush_frontend), 32'(ff));
        check({tag, ".fbe"}, 32'(flush_backend), 32'(fb));
        check({tag, ".epoch"}, 32'(epoch), 32'(ep));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    task automatic bru(input logic [4:0] tag, input logic [31:0] pc);
        bru_redirect_valid = 1;
        bru_redirect_tag   = tag;
        bru_redirect_pc    = pc;
    endtask

    initial begin
        rob_flush_valid = 0; bru_redirect_valid = 0; dec_redirect_valid = 0;
        rob_flush_pc = 0; bru_redirect_pc = 0; dec_redirect_pc = 0;
        bru_redirect_tag = 0; rob_head_tag = 0;

        // Reset state
        do_reset();
        outs("rst", 0, 32'h0, 0, 0, 0, 0);

        // Decode redirect in IDLE
        dec_redirect_valid = 1; dec_redirect_pc = 32'h40;
        tick();
        outs("dec.acc", 1, 32'h40, 1, 0, 1, 1);
        tick();
        outs("dec.d1", 0, 32'h40, 0, 0, 1, 1);
        tick();
        outs("dec.d2", 0, 32'h40, 0, 0, 1, 0);

        // Three-way collision: ROB wins, others dropped
        do_reset();
        rob_flush_valid = 1; rob_flush_pc = 32'h100;
        bru(5'd3, 32'h80);
        dec_redirect_valid = 1; dec_redirect_pc = 32'h40;
        tick();
        outs("col.acc", 1, 32'h100, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs("col.after", 0, 32'h100, 0, 0, 1, i < 1);
        end

        // Age filtering with head=0
        do_reset();
        rob_head_tag = 0;
        bru(5'd5, 32'h200);
        tick();
        outs("age.t5", 1, 32'h200, 1, 0, 1, 1);
        bru(5'd7, 32'h300);
        tick();
        outs("age.t7drop", 0, 32'h200, 0, 0, 1, 1);
        bru(5'd2, 32'h180);
        tick();
        outs("age.t2", 1, 32'h180, 1, 0, 2, 1);
        bru(5'd2, 32'h180);
        tick();
        outs("age.dup", 0, 32'h180, 0, 0, 2, 1);
        tick();
        outs("age.idle", 0, 32'h180, 0, 0, 2, 0);

        // Wrap-around age with head=30
        do_reset();
        rob_head_tag = 5'd30;
        bru(5'd1, 32'h500);
        tick();
        outs("wrap.t1", 1, 32'h500, 1, 0, 1, 1);
        bru(5'd31, 32'h600);
        tick();
        outs("wrap.t31", 1, 32'h600, 1, 0, 2, 1);
        rob_flush_valid = 1; rob_flush_pc = 32'h10;
        tick();
        outs("wrap.rob", 1, 32'h10, 1, 1, 3, 1);
        bru(5'd30, 32'h700);
        tick();
        outs("wrap.t30drop", 0, 32'h10, 0, 0, 3, 1);

        // Epoch wrap, reset mid-drain, dec right after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rob_flush_valid = 1; rob_flush_pc = 32'h1000 + 32'(i);
            tick();
            check("ep.step", 32'(epoch), 32'((i + 1) % 8));
        end
        outs("ep.wrap", 1, 32'h1007, 1, 1, 0, 1);
        reset = 1;
        tick();
        outs("ep.rst", 0, 32'h0, 0, 0, 0, 0);
        reset = 0;
        dec_redirect_valid = 1; dec_redirect_pc = 32'h44;
        tick();
        outs("ep.dec", 1, 32'h44, 1, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Arbitrates and sequences every PC redirect into the fetcher. Sources are the ROB (exception or commit-time flush), the branch unit (execute-stage mispredict) and decode (early JAL redirect). Picks one winner per cycle and drives the fetcher's take_branch/branch_loc pair as a registered one-cycle pulse. Issues frontend/backend flush pulses and an epoch tag. Runs a drain window that discards stale redirects from already-squashed younger instructions.

Parameters:
T, logic [31:0], address/PC type shared with fetcher
ROB_TAG_W, 5, ROB tag width
EPOCH_W, 3, epoch counter width
DRAIN_CYCLES, 2, cycles the drain window stays open after an accepted redirect (>=1)
RESET_PC, 32'h0, value of branch_loc out of reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rob_flush_valid  in  1  ROB requests full flush
rob_flush_pc  in  T  ROB restart PC
bru_redirect_valid  in  1  branch unit mispredict
bru_redirect_pc  in  T  corrected target
bru_redirect_tag  in  ROB_TAG_W  ROB tag of the mispredicted branch
rob_head_tag  in  ROB_TAG_W  current ROB head, used for age comparison
dec_redirect_valid  in  1  decode early redirect
dec_redirect_pc  in  T  decode target
take_branch  out  1  to fetcher; one-cycle pulse
branch_loc  out  T  to fetcher; redirect target
flush_frontend  out  1  pulse; squash fetch/decode
flush_backend  out  1  pulse; squash rename/issue/execute (ROB flush only)
epoch  out  EPOCH_W  increments on each accepted redirect
busy  out  1  high while in DRAIN

Behaviour:
- Reset values: take_branch=0, branch_loc=RESET_PC, flush_frontend=0, flush_backend=0, epoch=0, busy=0, state=IDLE, drain counter=0, recorded-tag-valid=0. Reset in DRAIN returns to IDLE and drops any pending or recorded redirect.
- Age: age(x) = (x - rob_head_tag) mod 2^ROB_TAG_W. Smaller age is older.
- States: IDLE, DRAIN.
- IDLE acceptance priority: rob > bru > dec. Only the winner is accepted; losers in the same cycle are dropped, not queued.
- Accept in cycle N gives these outputs in cycle N+1, all registered:
  - take_branch=1, branch_loc=winner PC, flush_frontend=1.
  - flush_backend=1 only if the winner is the ROB.
  - epoch+1, wrapping modulo 2^EPOCH_W.
  - state=DRAIN, counter=DRAIN_CYCLES, busy=1.
  - take_branch and the flush pulses are exactly one cycle wide. branch_loc holds its value until the next accept.
- Recorded tag: a bru winner stores its tag and sets recorded-tag-valid=1. A rob winner clears recorded-tag-valid.
- DRAIN acceptance:
  - rob_flush_valid is always accepted. Same outputs as above. Counter reloads to DRAIN_CYCLES. Recorded-tag-valid clears.
  - bru_redirect_valid is accepted only if recorded-tag-valid=1 and age(bru tag) < age(recorded tag). It then re-redirects, reloads the counter and records the new tag. Otherwise it is dropped.
  - dec_redirect_valid is always dropped in DRAIN.
  - With no accept, the counter decrements each cycle. When it reaches 0 the state returns to IDLE and busy falls. A request in the cycle busy=0 is evaluated under IDLE rules.
- An equal tag, age(new) == age(recorded), is dropped (duplicate report).
- No input handshake. Sources assert valid for one cycle and are not back-pressured. A dropped request is lost by design, because its issuer is squashed.

Test Plan:
- Reset 2 cycles, all requests low -> take_branch=0, branch_loc=0, epoch=0, busy=0, both flushes 0.
- IDLE, dec_redirect_valid=1 with pc=0x40 for one cycle -> next cycle take_branch=1, branch_loc=0x40, flush_frontend=1, flush_backend=0, epoch=1. busy=1 for 2 cycles, then 0. take_branch=0 after one cycle.
- Same cycle rob (0x100), bru (0x80, tag 3) and dec (0x40) -> branch_loc=0x100, flush_backend=1, epoch=1. The bru and dec requests are not seen later.
- Head=0. bru tag 5 (0x200) accepted. Next cycle bru tag 7 (0x300) -> dropped. Then bru tag 2 (0x180) -> accepted, branch_loc=0x180, epoch=2, busy extended by 2 cycles. Then bru tag 2 again -> dropped.
- Head=30. bru tag 1 accepted. Then bru tag 31 (age 1 < age 3) -> accepted, checking wrap-around age. Then rob flush 0x10 -> accepted, flush_backend=1. A following bru tag 30 in DRAIN -> dropped.
- Epoch wrap: 8 accepted redirects from 0 -> epoch returns to 0. Reset asserted mid-DRAIN -> busy=0 and epoch=0 next cycle. A dec redirect in the cycle after reset deasserts -> accepted.
